// File: rtl/button_enable_gen.sv
// Debounced push-button front end: produces one enable pulse per accepted press.
// Define BUTTON_AUTOREPEAT_EN to also emit repeat pulses while the button is held.
module button_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic button_n_i,
    output logic enable_o,
    output logic pressed_o
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Reject out-of-range timing parameters at elaboration.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 65535 ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : gBadParam
        $error("button_enable_gen: timing parameter outside 2..65535");
    end

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        sync1_q, sync2_q;
    logic        enable_q, enable_d;
    logic        pressed_q, pressed_d;
    logic        levelPressed;
    logic [15:0] countInc;

    assign levelPressed = ~sync2_q;
    assign countInc     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign enable_o     = enable_q;
    assign pressed_o    = pressed_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);

    // repeat_q distinguishes the initial delay from the steady repeat period.
    logic        repeat_q, repeat_d;
    logic [15:0] repeatLimit;

    assign repeatLimit = repeat_q ? RP_LAST : RD_LAST;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
`endif

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            count_q   <= 16'd0;
            enable_q  <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            sync1_q   <= button_n_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            count_q   <= count_d;
            enable_q  <= enable_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        enable_d  = 1'b0;
        pressed_d = pressed_q;
`ifdef BUTTON_AUTOREPEAT_EN
        repeat_d  = repeat_q;
`endif
        case (state_q)
            IDLE: begin
                if (levelPressed) begin
                    state_d = PRESS_DB;
                    count_d = 16'd0;
                end
            end
            PRESS_DB: begin
                if (!levelPressed) begin
                    state_d = IDLE;
                    count_d = 16'd0;
                end else if (count_q >= DB_LAST) begin
                    state_d   = HELD;
                    count_d   = 16'd0;
                    enable_d  = 1'b1;
                    pressed_d = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                    repeat_d  = 1'b0;
`endif
                end else begin
                    count_d = countInc;
                end
            end
            HELD: begin
                if (!levelPressed) begin
                    state_d = RELEASE_DB;
                    count_d = 16'd0;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else if (count_q >= repeatLimit) begin
                    enable_d = 1'b1;
                    count_d  = 16'd0;
                    repeat_d = 1'b1;
                end else begin
                    count_d = countInc;
                end
`endif
            end
            RELEASE_DB: begin
                // A re-press bounce returns to HELD silently and restarts repeat timing.
                if (levelPressed) begin
                    state_d = HELD;
                    count_d = 16'd0;
`ifdef BUTTON_AUTOREPEAT_EN
                    repeat_d = 1'b0;
`endif
                end else if (count_q >= DB_LAST) begin
                    state_d   = IDLE;
                    count_d   = 16'd0;
                    pressed_d = 1'b0;
                end else begin
                    count_d = countInc;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_enable_gen.sv
// Scoreboard bench for button_enable_gen: expected pulse cycles are queued when a
// press is driven and matched against enable_o as pulses appear.
module tb_button_enable_gen;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    logic buttonN = 1'b1;
    logic enable;
    logic pressed;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int expQ[$];
    int k, k2, r, r2;

    button_enable_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock_i   (clock),
        .reset_n_i (resetN),
        .button_n_i(buttonN),
        .enable_o  (enable),
        .pressed_o (pressed)
    );

    always #5 clock = ~clock;

    // After rising edge n, cyc holds n until the next rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(string tag, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitUntil(int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic applyStimulus(logic level, int cycles);
        buttonN = level;
        repeat (cycles) @(negedge clock);
    endtask

    // k = first edge sampling the low level, heldEdges = edges sampling it low.
    task automatic expectPress(int firstEdge, int heldEdges);
        int p;
        p = firstEdge + 2 + DB;
        expQ.push_back(p);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int t = p + RD; t <= firstEdge + heldEdges + 1; t += RP) expQ.push_back(t);
`endif
    endtask

    // Pulse monitor: retire overdue expectations, then match any pulse seen.
    always @(negedge clock) begin
        while (expQ.size() > 0 && expQ[0] < cyc) begin
            checkOutput("pulse_missing", -1, expQ[0]);
            void'(expQ.pop_front());
        end
        if (enable === 1'b1) begin
            if (expQ.size() == 0) checkOutput("pulse_unexpected", cyc, -1);
            else checkOutput("pulse_cycle", cyc, expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN  = 1'b0;
        buttonN = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_enable", enable, 0);
        checkOutput("reset_pressed", pressed, 0);
        resetN = 1'b1;
        repeat (5) @(negedge clock);

        // Clean press held 50 cycles, then clean release.
        k = cyc + 1;
        buttonN = 1'b0;
        expectPress(k, 50);
        waitUntil(k + 2 + DB - 1);
        checkOutput("s1_pressed_pre", pressed, 0);
        waitUntil(k + 2 + DB);
        checkOutput("s1_pressed_set", pressed, 1);
        waitUntil(k + 49);
        buttonN = 1'b1;
        r = k + 50;
        waitUntil(r + 1 + DB);
        checkOutput("s1_pressed_hold", pressed, 1);
        waitUntil(r + 2 + DB);
        checkOutput("s1_pressed_clear", pressed, 0);
        repeat (10) @(negedge clock);

        // Three 2-cycle low glitches separated by 2 high cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2);
            applyStimulus(1'b1, 2);
            checkOutput("s2_glitch_pressed", pressed, 0);
        end
        repeat (10) @(negedge clock);
        checkOutput("s2_final_pressed", pressed, 0);

        // Accepted press, release with a 2-cycle re-press bounce, then clean release.
        k = cyc + 1;
        buttonN = 1'b0;
        expectPress(k, 20);
        waitUntil(k + 19);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        checkOutput("s3_pressed_bounce", pressed, 1);
        buttonN = 1'b1;
        r2 = cyc + 1;
        waitUntil(r2 + 1 + DB);
        checkOutput("s3_pressed_hold", pressed, 1);
        waitUntil(r2 + 2 + DB);
        checkOutput("s3_pressed_clear", pressed, 0);
        repeat (10) @(negedge clock);

        // Reset while debouncing (counter 3), button kept held through reset release.
        k = cyc + 1;
        buttonN = 1'b0;
        waitUntil(k + 5);
        resetN = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("s4_reset_enable", enable, 0);
        checkOutput("s4_reset_pressed", pressed, 0);
        resetN = 1'b1;
        k2 = cyc + 1;
        expectPress(k2, 10);
        waitUntil(k2 + 2 + DB - 1);
        checkOutput("s4_pressed_pre", pressed, 0);
        waitUntil(k2 + 2 + DB);
        checkOutput("s4_pressed_set", pressed, 1);
        waitUntil(k2 + 9);
        buttonN = 1'b1;
        waitUntil(k2 + 10 + 2 + DB);
        checkOutput("s4_pressed_clear", pressed, 0);
        repeat (10) @(negedge clock);

        // Long hold: auto-repeat pulses when the feature is built in.
        k = cyc + 1;
        buttonN = 1'b0;
        expectPress(k, 70);
        waitUntil(k + 69);
        buttonN = 1'b1;
        waitUntil(k + 70 + 2 + DB);
        checkOutput("s5_pressed_clear", pressed, 0);
        repeat (10) @(negedge clock);

        // Reset landing on the edge that would start the pulse suppresses it.
        k = cyc + 1;
        buttonN = 1'b0;
        waitUntil(k + 2 + DB - 1);
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("s6_enable_suppressed", enable, 0);
        checkOutput("s6_pressed_suppressed", pressed, 0);
        buttonN = 1'b1;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        repeat (10) @(negedge clock);

        checkOutput("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_enable_gen.md
BUTTON_ENABLE_GEN -- requirements
Module: button_enable_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized cycles the new level must hold before the debounced level changes; legal range 2..65535.
REQ-002 Parameter REPEAT_DELAY, default 64: cycles held before the first auto-repeat pulse; legal range 2..65535.
REQ-003 Parameter REPEAT_PERIOD, default 16: cycles between subsequent auto-repeat pulses; legal range 2..65535.
REQ-004 clock_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n_i  input  1  reset, synchronous, active-low.
REQ-006 button_n_i  input  1  raw push-button, active-low, asynchronous to clock_i, may bounce.
REQ-007 enable_o  output  1  one-cycle pulse per accepted press (and per repeat); drives a counter enable_i.
REQ-008 pressed_o  output  1  debounced button level, 1 = pressed.

Function
REQ-009 button_n_i SHALL pass through a 2-flop synchronizer before any other use; synchronizer flops reset to 1 (released).
REQ-010 FSM states SHALL be IDLE, PRESS_DB, HELD, RELEASE_DB; a 16-bit counter SHALL provide debounce and repeat timing.
REQ-011 IDLE: synchronized level pressed -> PRESS_DB, counter cleared; otherwise stay.
REQ-012 PRESS_DB: counter increments each cycle level is pressed; level released (bounce) -> IDLE, no pulse; counter reaching DEBOUNCE_CYCLES-1 with level pressed -> HELD.
REQ-013 Transition PRESS_DB -> HELD SHALL assert enable_o for exactly the following one cycle and set pressed_o in that same cycle.
REQ-014 Latency: button_n_i first sampled low at edge k and held low -> enable_o high in the cycle after edge k+2+DEBOUNCE_CYCLES.
REQ-015 HELD: synchronized level released -> RELEASE_DB, counter cleared; pressed_o stays 1.
REQ-016 RELEASE_DB: level pressed (bounce) -> HELD with no new pulse and repeat timing restarted; level released for DEBOUNCE_CYCLES consecutive cycles -> IDLE, pressed_o cleared.
REQ-017 enable_o SHALL never be high for two consecutive cycles.
REQ-018 Counter SHALL saturate at 16'hFFFF, never wrap.
REQ-019 Bounce shorter than DEBOUNCE_CYCLES in either direction SHALL produce no pulse and no change of pressed_o.

Reset
REQ-020 reset_n_i low at a rising edge SHALL force state IDLE, counter 0, synchronizer flops 1, enable_o 0, pressed_o 0.
REQ-021 Reset asserted mid-operation (any state, including the pulse cycle) SHALL take effect at the next edge, suppressing any pending pulse.
REQ-022 After reset release with button held, a full press debounce SHALL be required before the first pulse.

Configuration
REQ-023 Macro BUTTON_AUTOREPEAT_EN SHALL control auto-repeat.
REQ-024 With BUTTON_AUTOREPEAT_EN defined: in HELD, counter counts held cycles; at REPEAT_DELAY cycles after entering HELD emit one pulse, then one pulse every REPEAT_PERIOD cycles while held.
REQ-025 Without BUTTON_AUTOREPEAT_EN: exactly one pulse per accepted press regardless of hold time; REPEAT_DELAY/REPEAT_PERIOD unused, no repeat logic synthesized.

Verification
REQ-026 DEBOUNCE_CYCLES=4: button_n_i low from edge 10, held 50 cycles -> single enable_o pulse in cycle after edge 16; pressed_o 1 from same cycle.
REQ-027 DEBOUNCE_CYCLES=4: three low glitches of 2 cycles separated by 2 high cycles -> enable_o never asserted, pressed_o stays 0.
REQ-028 Press accepted, then release with 2-cycle re-press bounce, then clean release -> no second pulse; pressed_o 0 four cycles after final stable release reaches synchronizer.
REQ-029 reset_n_i low during PRESS_DB at counter 3 -> no pulse, all outputs 0; button still held after release -> pulse 6 cycles after first post-reset sample.
REQ-030 BUTTON_AUTOREPEAT_EN defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, held 60 cycles in HELD -> pulses at HELD+0, +20, +28, +36, +44, +52; undefined -> only HELD+0.
REQ-031 Press held through reset release -> no pulse until 2+DEBOUNCE_CYCLES cycles after reset deassertion.
